// File: rtl/twi_pkg.sv
// Shared definitions for the TWI master and its command sequencer:
// command codes, status/command word field positions and error codes.
package twi_pkg;

  typedef enum logic [2:0] {
    CMD_START   = 3'd0,
    CMD_WR      = 3'd1,
    CMD_RD      = 3'd2,
    CMD_STOP    = 3'd3,
    CMD_RESTART = 3'd4,
    CMD_ADDRESS = 3'd5,
    CMD_NOP     = 3'd7
  } CMD_e;

  localparam int STAT_READY = 8;
  localparam int STAT_ACK   = 9;
  localparam int CMD_LSB    = 8;
  localparam int CMD_MSB    = 10;

  typedef enum logic [1:0] {
    ERR_OK        = 2'd0,
    ERR_ADDR_NACK = 2'd1,
    ERR_DATA_NACK = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACC,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_DONE,
    ST_ABORT
  } seq_state_e;

  typedef enum logic [2:0] {
    PH_START,
    PH_ADDR_W,
    PH_REG,
    PH_WDATA,
    PH_RESTART,
    PH_ADDR_R,
    PH_RDATA,
    PH_STOP
  } seq_phase_e;

  function automatic logic [CMD_MSB:0] twi_word(CMD_e cmd, logic [CMD_LSB-1:0] payload);
    logic [CMD_MSB:0] w;
    w = '0;
    w[CMD_MSB:CMD_LSB] = cmd;
    w[CMD_LSB-1:0]     = payload;
    return w;
  endfunction

endpackage

// File: rtl/twi_cmd_timer.sv
// Loadable down-counter with a zero flag; bounds how long the sequencer
// waits on the master for any single command.
module twi_cmd_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/twi_cmd_sequencer.sv
// Expands one register-oriented I2C request into the TWI master's command
// stream, handshaking each command on the master's ready/ack status.
module twi_cmd_sequencer
  import twi_pkg::*;
#(
  parameter int SIZE_ADDR = 7,
  parameter int SIZE_DATA = 8,
  parameter int SIZE_REG  = 16,
  parameter int LEN_W     = 4,
  parameter int TMO_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_rw,
  input  logic [SIZE_ADDR-1:0] i_req_addr,
  input  logic [SIZE_DATA-1:0] i_req_reg,
  input  logic [LEN_W-1:0]     i_req_len,
  input  logic [TMO_W-1:0]     i_tmo,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  output logic [SIZE_DATA-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_err,
  output logic                 o_TWIEN,
  output logic [SIZE_REG-1:0]  o_TWIWD,
  input  logic [SIZE_REG-1:0]  i_TWIRD
);

  seq_state_e state_q, state_d;
  seq_phase_e phase_q, phase_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  err_e err_q, err_d;

  logic                 rw_q;
  logic [SIZE_ADDR-1:0] addr_q;
  logic [SIZE_DATA-1:0] reg_q;
  logic                 ack_q;
  logic [SIZE_DATA-1:0] stat_byte_q;
  logic [SIZE_DATA-1:0] rd_data_q;
  logic                 rd_valid_q;

  logic [CMD_MSB:0] phase_word;
  logic [CMD_MSB:0] cmd_word;
  logic accept, capture, rd_pulse, wr_ready_c;
  logic tmr_load, tmr_dec, tmr_zero;
  logic data_stall, last_byte, mst_ready;
  logic unused_status;

  assign mst_ready     = i_TWIRD[STAT_READY];
  assign last_byte     = (cnt_q == LEN_W'(1));
  assign data_stall    = (phase_q == PH_WDATA) && !i_wr_valid;
  assign accept        = (state_q == ST_IDLE) && i_req_valid;
  assign unused_status = ^i_TWIRD[SIZE_REG-1:STAT_ACK+1];

  twi_cmd_timer #(.W(TMO_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .load       (tmr_load),
    .load_value (i_tmo),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  always_comb begin
    phase_word = twi_word(CMD_NOP, 8'h00);
    case (phase_q)
      PH_START:   phase_word = twi_word(CMD_START, 8'h00);
      PH_ADDR_W:  phase_word = twi_word(CMD_ADDRESS, {1'b0, addr_q});
      PH_REG:     phase_word = twi_word(CMD_WR, reg_q);
      PH_WDATA:   phase_word = twi_word(CMD_WR, i_wr_data);
      PH_RESTART: phase_word = twi_word(CMD_RESTART, 8'h00);
      PH_ADDR_R:  phase_word = twi_word(CMD_ADDRESS, {1'b1, addr_q});
      PH_RDATA:   phase_word = twi_word(CMD_RD, {7'b0, last_byte});
      PH_STOP:    phase_word = twi_word(CMD_STOP, 8'h00);
      default:    phase_word = twi_word(CMD_NOP, 8'h00);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    cmd_word   = twi_word(CMD_NOP, 8'h00);
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    capture    = 1'b0;
    rd_pulse   = 1'b0;
    wr_ready_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          state_d  = ST_ISSUE;
          phase_d  = PH_START;
          cnt_d    = (i_req_len == '0) ? LEN_W'(1) : i_req_len;
          err_d    = ERR_OK;
          tmr_load = 1'b1;
        end
      end

      // Waiting for write data keeps the timer reloaded so the stall is not charged to the master.
      ST_ISSUE: begin
        if (data_stall) begin
          tmr_load = 1'b1;
        end else if (mst_ready) begin
          cmd_word   = phase_word;
          tmr_load   = 1'b1;
          wr_ready_c = (phase_q == PH_WDATA);
          state_d    = ST_WAIT_ACC;
        end else if (tmr_zero) begin
          state_d = ST_ABORT;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_WAIT_ACC: begin
        if (!mst_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (tmr_zero) begin
          state_d = ST_ABORT;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (mst_ready) begin
          capture = 1'b1;
          state_d = ST_CHECK;
        end else if (tmr_zero) begin
          state_d = ST_ABORT;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_CHECK: begin
        state_d  = ST_ISSUE;
        tmr_load = 1'b1;
        case (phase_q)
          PH_START:   phase_d = PH_ADDR_W;
          PH_RESTART: phase_d = PH_ADDR_R;
          PH_ADDR_W, PH_ADDR_R: begin
            if (ack_q) begin
              err_d   = ERR_ADDR_NACK;
              phase_d = PH_STOP;
            end else begin
              phase_d = (phase_q == PH_ADDR_W) ? PH_REG : PH_RDATA;
            end
          end
          PH_REG: begin
            if (ack_q) begin
              err_d   = ERR_DATA_NACK;
              phase_d = PH_STOP;
            end else begin
              phase_d = rw_q ? PH_RESTART : PH_WDATA;
            end
          end
          PH_WDATA: begin
            if (ack_q) begin
              err_d   = ERR_DATA_NACK;
              phase_d = PH_STOP;
            end else if (last_byte) begin
              phase_d = PH_STOP;
            end else begin
              cnt_d = cnt_q - LEN_W'(1);
            end
          end
          PH_RDATA: begin
            rd_pulse = 1'b1;
            if (last_byte) begin
              phase_d = PH_STOP;
            end else begin
              cnt_d = cnt_q - LEN_W'(1);
            end
          end
          PH_STOP: begin
            state_d  = ST_DONE;
            tmr_load = 1'b0;
          end
          default: state_d = ST_DONE;
        endcase
      end

      ST_ABORT: begin
        err_d   = ERR_TIMEOUT;
        state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_START;
      cnt_q       <= '0;
      err_q       <= ERR_OK;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      reg_q       <= '0;
      ack_q       <= 1'b0;
      stat_byte_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_pulse;
      if (accept) begin
        rw_q   <= i_req_rw;
        addr_q <= i_req_addr;
        reg_q  <= i_req_reg;
      end
      if (capture) begin
        ack_q       <= i_TWIRD[STAT_ACK];
        stat_byte_q <= i_TWIRD[SIZE_DATA-1:0];
      end
      if (rd_pulse) begin
        rd_data_q <= stat_byte_q;
      end
    end
  end

  // Enable drops in IDLE and for the single ABORT cycle, which forces the master back to idle.
  assign o_TWIEN     = (state_q != ST_IDLE) && (state_q != ST_ABORT);
  assign o_TWIWD     = {{(SIZE_REG-CMD_MSB-1){1'b0}}, cmd_word};
  assign o_req_ready = (state_q == ST_IDLE) && i_rst_n;
  assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = err_q;
  assign o_wr_ready  = wr_ready_c;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_twi_cmd_sequencer.sv
// Self-checking bench: a behavioural TWI master emulator feeds the sequencer, and a
// list-based reference model predicts the command stream, byte handshakes and error code.
module tb_twi_cmd_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_rw = 1'b0;
  logic [6:0]  i_req_addr = '0;
  logic [7:0]  i_req_reg = '0;
  logic [3:0]  i_req_len = '0;
  logic [15:0] i_tmo = 16'd100;
  logic [7:0]  i_wr_data = '0;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_err;
  logic        o_TWIEN;
  logic [15:0] o_TWIWD;
  logic [15:0] i_TWIRD = 16'h0100;

  twi_cmd_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_rw(i_req_rw), .i_req_addr(i_req_addr), .i_req_reg(i_req_reg), .i_req_len(i_req_len),
    .i_tmo(i_tmo), .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_TWIEN(o_TWIEN), .o_TWIWD(o_TWIWD), .i_TWIRD(i_TWIRD)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Environment state shared between the master emulator and the test sequence.
  logic [15:0] cmd_log[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  wq[$];
  logic [7:0]  rd_src[$];
  int  wr_pulses, done_cnt, done_err, twien_low, low_cyc, issue_cyc, cyc;
  int  cmd_idx, nack_idx_m;
  int  lat_min = 0, lat_max = 2;
  bit  txn_active = 0, hang = 0, gap_en = 0;
  bit  m_ready = 1, m_ack = 0, m_pend_nack = 0;
  int  m_lat = 0;
  logic [7:0] m_byte = '0, m_pend_byte = '0;

  // Reference model outputs
  logic [15:0] exp_words[$];
  logic [7:0]  exp_rd[$];
  int exp_err, exp_wr;

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  regp;
    logic [3:0]  len;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          nack;
    int          exp_err;
    int          exp_ncmd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] mk(int cmd, int pl);
    return 16'(cmd * 256 + (pl % 256));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Emulated master: sample at negedge, respond just after posedge.
  initial begin
    logic [15:0] w;
    bit iss, taken, en;
    forever begin
      @(negedge i_clk);
      cyc++;
      w     = o_TWIWD;
      iss   = (w[10:8] != 3'd7);
      taken = o_wr_ready;
      en    = o_TWIEN;
      if (iss) begin
        cmd_log.push_back(w);
        issue_cyc = cyc;
      end
      if (o_wr_ready === 1'b1) wr_pulses++;
      if (o_rd_valid === 1'b1) rd_log.push_back(o_rd_data);
      if (txn_active && !en) begin
        twien_low++;
        low_cyc = cyc;
      end
      if (o_done === 1'b1) begin
        done_cnt++;
        done_err = int'(o_err);
        txn_active = 0;
      end
      @(posedge i_clk);
      #1;
      if (!en) begin
        m_ready = 1;
        m_lat = 0;
        m_ack = 0;
      end else if (iss) begin
        m_ready = 0;
        m_lat = int'($urandom_range(lat_max, lat_min));
        m_pend_nack = (cmd_idx == nack_idx_m);
        m_pend_byte = 8'h00;
        if (w[10:8] == 3'd2 && rd_src.size() > 0) m_pend_byte = rd_src.pop_front();
        cmd_idx++;
      end else if (!m_ready && !hang) begin
        if (m_lat > 0) m_lat--;
        else begin
          m_ready = 1;
          m_ack = m_pend_nack;
          m_byte = m_pend_byte;
        end
      end
      if (taken && wq.size() > 0) void'(wq.pop_front());
      i_wr_valid = (wq.size() > 0) && (!gap_en || $urandom_range(3, 0) != 0);
      i_wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
      i_TWIRD    = {6'b0, m_ack, m_ready, m_byte};
    end
  end

  // Builds the full command list for a request, then truncates it at the first NACKed
  // ADDRESS/WR and closes with STOP.
  task automatic buildExpected(input logic rw, input logic [6:0] addr, input logic [7:0] regp,
                               input logic [3:0] len, input logic [63:0] wd, input logic [63:0] rdat,
                               input int nack);
    logic [15:0] full[$];
    int kind[$];
    int n, rdi;
    n = (len == 0) ? 1 : int'(len);
    exp_words.delete();
    exp_rd.delete();
    exp_err = 0;
    exp_wr = 0;
    rdi = 0;
    full.push_back(mk(0, 0));        kind.push_back(0);
    full.push_back(mk(5, int'(addr))); kind.push_back(1);
    full.push_back(mk(1, int'(regp))); kind.push_back(2);
    if (!rw) begin
      for (int i = 0; i < n; i++) begin
        full.push_back(mk(1, int'(wd[8*i +: 8]))); kind.push_back(3);
      end
    end else begin
      full.push_back(mk(4, 0));               kind.push_back(0);
      full.push_back(mk(5, 128 + int'(addr))); kind.push_back(1);
      for (int i = 0; i < n; i++) begin
        full.push_back(mk(2, (i == n - 1) ? 1 : 0)); kind.push_back(4);
      end
    end
    for (int i = 0; i < full.size(); i++) begin
      exp_words.push_back(full[i]);
      if (kind[i] == 3) exp_wr++;
      if (kind[i] == 4) begin
        exp_rd.push_back(rdat[8*rdi +: 8]);
        rdi++;
      end
      if (i == nack && kind[i] >= 1 && kind[i] <= 3) begin
        exp_err = (kind[i] == 1) ? 1 : 2;
        break;
      end
    end
    exp_words.push_back(mk(3, 0));
  endtask

  task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] regp,
                               input logic [3:0] len, input logic [63:0] wd, input logic [63:0] rdat,
                               input int nack, input logic [15:0] tmo);
    int n, guard;
    n = (len == 0) ? 1 : int'(len);
    cmd_log.delete(); rd_log.delete(); wq.delete(); rd_src.delete();
    wr_pulses = 0; done_cnt = 0; done_err = -1; twien_low = 0;
    cmd_idx = 0; nack_idx_m = nack;
    for (int i = 0; i < n; i++) begin
      if (!rw) wq.push_back(wd[8*i +: 8]);
      else rd_src.push_back(rdat[8*i +: 8]);
    end
    guard = 0;
    while (o_req_ready !== 1'b1 && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 200) checkOutput("req_ready_wait", 0, 1);
    @(posedge i_clk);
    #1;
    i_req_rw = rw; i_req_addr = addr; i_req_reg = regp; i_req_len = len; i_tmo = tmo;
    i_req_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_addr = ~addr;
    txn_active = 1;
  endtask

  task automatic waitDone(input string name);
    int guard;
    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 3000) checkOutput({name, "_done_wait"}, 0, 1);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic checkTxn(input string name);
    checkOutput({name, "_done_cnt"}, 32'(done_cnt), 1);
    checkOutput({name, "_err"}, 32'(done_err), 32'(exp_err));
    checkOutput({name, "_ncmd"}, 32'(cmd_log.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < cmd_log.size(); i++)
      checkOutput($sformatf("%s_word%0d", name, i), 32'(cmd_log[i]), 32'(exp_words[i]));
    checkOutput({name, "_wr_ready"}, 32'(wr_pulses), 32'(exp_wr));
    checkOutput({name, "_nrd"}, 32'(rd_log.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      checkOutput($sformatf("%s_rd%0d", name, i), 32'(rd_log[i]), 32'(exp_rd[i]));
    checkOutput({name, "_twien_low"}, 32'(twien_low), 0);
    checkOutput({name, "_idle_busy"}, 32'(o_busy), 0);
    checkOutput({name, "_idle_ready"}, 32'(o_req_ready), 1);
  endtask

  initial begin
    int d, guard;
    logic rw;
    logic [3:0] len;
    int nack;

    vecs[0] = '{1'b0, 7'h50, 8'h10, 4'd2, 64'h3CA5,     64'h0,      -1, 0, 6, 2};
    vecs[1] = '{1'b1, 7'h68, 8'h75, 4'd3, 64'h0,        64'h332211, -1, 0, 9, 0};
    vecs[2] = '{1'b0, 7'h2A, 8'h01, 4'd2, 64'h7766,     64'h0,       1, 1, 3, 0};
    vecs[3] = '{1'b0, 7'h3B, 8'h20, 4'd4, 64'h44332211, 64'h0,       4, 2, 6, 2};
    vecs[4] = '{1'b0, 7'h11, 8'hFF, 4'd0, 64'h5A,       64'h0,      -1, 0, 5, 1};
    vecs[5] = '{1'b1, 7'h22, 8'h33, 4'd2, 64'h0,        64'hBBAA,    2, 2, 4, 0};
    vecs[6] = '{1'b1, 7'h44, 8'h55, 4'd1, 64'h0,        64'hCC,      4, 1, 6, 0};
    vecs[7] = '{1'b1, 7'h7F, 8'h00, 4'd1, 64'h0,        64'h99,     -1, 0, 7, 0};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_twiwd", 32'(o_TWIWD), 32'h0700);
    checkOutput("rst_twien", 32'(o_TWIEN), 0);
    checkOutput("rst_req_ready", 32'(o_req_ready), 0);
    checkOutput("rst_busy_done", 32'({o_busy, o_done, o_wr_ready, o_rd_valid}), 0);
    checkOutput("rst_err", 32'(o_err), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("post_rst_req_ready", 32'(o_req_ready), 1);

    for (int v = 0; v < 8; v++) begin
      $display("[TB] vector %0d", v);
      buildExpected(vecs[v].rw, vecs[v].addr, vecs[v].regp, vecs[v].len,
                    vecs[v].wdata, vecs[v].rdata, vecs[v].nack);
      applyStimulus(vecs[v].rw, vecs[v].addr, vecs[v].regp, vecs[v].len,
                    vecs[v].wdata, vecs[v].rdata, vecs[v].nack, 16'd100);
      waitDone($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_tbl_err", v), 32'(done_err), 32'(vecs[v].exp_err));
      checkOutput($sformatf("vec%0d_tbl_ncmd", v), 32'(cmd_log.size()), 32'(vecs[v].exp_ncmd));
      checkOutput($sformatf("vec%0d_tbl_wr", v), 32'(wr_pulses), 32'(vecs[v].exp_wr));
      checkTxn($sformatf("vec%0d", v));
    end

    // Master accepts START but never completes: expect a single-cycle enable drop.
    $display("[TB] timeout sequence");
    hang = 1;
    applyStimulus(1'b0, 7'h50, 8'h10, 4'd2, 64'h1234, 64'h0, -1, 16'd20);
    waitDone("tmo");
    d = low_cyc - issue_cyc;
    checkOutput("tmo_err", 32'(done_err), 3);
    checkOutput("tmo_done_cnt", 32'(done_cnt), 1);
    checkOutput("tmo_twien_low_cycles", 32'(twien_low), 1);
    checkOutput("tmo_delay_in_window", 32'(d >= 18 && d <= 26), 1);
    checkOutput("tmo_ncmd_no_stop", 32'(cmd_log.size()), 1);
    if (cmd_log.size() > 0) checkOutput("tmo_first_cmd", 32'(cmd_log[0]), 32'(mk(0, 0)));
    checkOutput("tmo_wr_ready", 32'(wr_pulses), 0);
    hang = 0;

    // Reset pulse while the second command is outstanding.
    $display("[TB] mid-transaction reset sequence");
    lat_min = 8; lat_max = 8;
    applyStimulus(1'b0, 7'h33, 8'h44, 4'd3, 64'h030201, 64'h0, -1, 16'd100);
    guard = 0;
    while (cmd_log.size() < 2 && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 200) checkOutput("rst_mid_wait", 0, 1);
    repeat (2) @(posedge i_clk);
    #1;
    txn_active = 0;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("rst_mid_twien", 32'(o_TWIEN), 0);
    checkOutput("rst_mid_twiwd", 32'(o_TWIWD), 32'h0700);
    checkOutput("rst_mid_req_ready", 32'(o_req_ready), 1);
    checkOutput("rst_mid_busy", 32'(o_busy), 0);
    repeat (12) @(negedge i_clk);
    checkOutput("rst_mid_no_stop", 32'(cmd_log.size()), 2);
    checkOutput("rst_mid_no_done", 32'(done_cnt), 0);
    lat_min = 0; lat_max = 2;

    // Randomized transactions against the reference model.
    gap_en = 1;
    for (int t = 0; t < 25; t++) begin
      logic [63:0] wd, rdat;
      logic [6:0] a;
      logic [7:0] r;
      rw   = 1'($urandom_range(1, 0));
      len  = 4'($urandom_range(8, 0));
      nack = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(12, 0));
      wd   = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      a    = 7'($urandom);
      r    = 8'($urandom);
      buildExpected(rw, a, r, len, wd, rdat, nack);
      applyStimulus(rw, a, r, len, wd, rdat, nack, 16'd200);
      waitDone($sformatf("rnd%0d", t));
      checkTxn($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twi_cmd_sequencer.md
Name: twi_cmd_sequencer

Overview:
- Transaction-level front end for the TWI master.
- Accepts one register-oriented I2C request: slave address, 8-bit register pointer, 1..MAX_LEN data bytes, read or write.
- Expands it into the master's command-word stream (START, ADDRESS, WR, RESTART, RD, STOP), handshaking on the master's ready/ack status.
- Sits directly upstream of the master. It drives the master's TWIEN and TWIWD inputs and consumes its TWIRD output.

Parameters:
- SIZE_ADDR, 7, slave address width.
- SIZE_DATA, 8, data byte width.
- SIZE_REG, 16, master command/status word width.
- LEN_W, 4, byte-count width; max transfer length 2^LEN_W-1.
- TMO_W, 16, width of the per-command timeout counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req_valid  in  1  request strobe; accepted when o_req_ready=1.
- o_req_ready  out  1  high only in IDLE.
- i_req_rw  in  1  0=write, 1=read.
- i_req_addr  in  SIZE_ADDR  7-bit slave address.
- i_req_reg  in  SIZE_DATA  register pointer.
- i_req_len  in  LEN_W  byte count; 0 is treated as 1.
- i_tmo  in  TMO_W  timeout, in clocks, per command.
- i_wr_data  in  SIZE_DATA  write byte.
- i_wr_valid  in  1  write byte available.
- o_wr_ready  out  1  pulses 1 cycle when i_wr_data is consumed.
- o_rd_data  out  SIZE_DATA  read byte.
- o_rd_valid  out  1  1-cycle pulse per read byte; no backpressure.
- o_busy  out  1  transaction in progress.
- o_done  out  1  1-cycle pulse at transaction end.
- o_err  out  2  0=OK, 1=address NACK, 2=data/register NACK, 3=timeout; valid with o_done and held until the next accept.
- o_TWIEN  out  1  master enable.
- o_TWIWD  out  SIZE_REG  master command word.
- i_TWIRD  in  SIZE_REG  master status word.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is synchronous and active-low.
- Reset values: o_TWIWD = NOP (cmd 7, data 0); all other outputs 0.

Master word format:
- Command word: cmd in [10:8] (START=0, WR=1, RD=2, STOP=3, RESTART=4, ADDRESS=5, NOP=7); payload in [7:0].
- ADDRESS payload: [6:0]=addr, [7]=R/W.
- RD payload: [0]=1 requests NACK after the byte (set on the last byte).
- Status word: [7:0] read byte; [8] ready (master accepts commands); [9] ack (1=NACK, from the last WR/ADDRESS).

Command handshake:
- The sequencer places a command on o_TWIWD for exactly one cycle, and only while ready=1. Otherwise o_TWIWD = NOP.
- It then waits for ready=0 (accepted), then ready=1 (complete), then samples ack and the read byte on that ready=1 cycle.
- Timeout counter loads i_tmo at issue and decrements in each wait state. Reaching 0 means timeout.

FSM states: IDLE, ISSUE, WAIT_ACC, WAIT_DONE, CHECK, DONE, ABORT.
- A phase register selects the next command.
- Write sequence: START, ADDR(W), WR(reg), WR(data) ×len, STOP.
- Read sequence: START, ADDR(W), WR(reg), RESTART, ADDR(R), RD ×len (last with NACK bit), STOP.

Sequencing rules:
- In a WR(data) phase, ISSUE stalls, with the timeout not running, until i_wr_valid=1. o_wr_ready pulses in the issue cycle.
- In CHECK:
  - After ADDR, ack=1 sets err=1 and jumps to the STOP phase.
  - After WR, ack=1 sets err=2 and jumps to STOP; remaining bytes are not consumed.
  - After RD, the byte goes to o_rd_data and o_rd_valid pulses.
- Timeout → ABORT: o_TWIEN=0 for exactly 1 cycle (forces master to idle), no STOP is issued, err=3, then DONE.
- o_TWIEN=1 from accept through DONE, except in ABORT.
- DONE: o_done pulses, o_busy drops, return to IDLE. A new request can be accepted on the next cycle.
- i_req_valid outside IDLE is ignored. Request fields are latched at accept.
- Byte counter counts down from the latched len; the last byte is at count 1.
- Reset mid-transaction returns to IDLE next cycle with o_TWIEN=0. No STOP is sent.

Decomposition:
- Package twi_pkg holds:
  - the CMD_e enum (including NOP=7);
  - status bit indices (READY=8, ACK=9);
  - the command-field position [10:8];
  - the error-code enum.
- The master and the sequencer both import twi_pkg.
- Sub-module twi_cmd_timer is the loadable down-counter with a zero flag.

Test Plan:
- Write, addr 0x50, reg 0x10, len 2, data A5,3C, slave always ACK → TWIWD cmd/payload sequence 0/00, 5/50, 1/10, 1/A5, 1/3C, 3/00; two o_wr_ready pulses; o_done with err=0.
- Read, addr 0x68, reg 0x75, len 3, model returns 11,22,33 → 0,5/68,1/75,4,5/E8,2/00,2/00,2/01,3; o_rd_valid ×3 with 11,22,33; err=0.
- Address NACK on the first ADDR → STOP issued next, no WR issued, no o_wr_ready, err=1.
- NACK on the 2nd data byte of a len 4 write → STOP follows, exactly 2 o_wr_ready pulses, err=2.
- Model never re-asserts ready, i_tmo=20 → o_TWIEN low for exactly 1 cycle about 20 cycles after issue, err=3, o_done.
- i_rst_n low for 1 cycle during WAIT_DONE → next cycle IDLE, o_TWIEN=0, o_TWIWD=NOP, o_req_ready=1.
